// File: rtl/decoder_bist_pkg.sv
// decoder_bist_pkg: shared types, constants and the ideal one-hot helper for the decoder BIST
package decoder_bist_pkg;

    // Widest decoder input the helper supports; callers truncate to 2^N bits.
    localparam int MAXN = 8;
    localparam int CNTW = 4;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    function automatic logic [2**MAXN-1:0] onehot_of(input logic [MAXN-1:0] a);
        onehot_of = '0;
        onehot_of[a] = 1'b1;
    endfunction

endpackage

// File: rtl/decoder_bist_if.sv
// decoder_bist_if: bundle between the BIST controller, the decoder under test and the system
//   start           run request into the BIST
//   dec_a / dec_y   code driven to the decoder and its one-hot response
//   busy/done/pass  run status
//   err_count       saturating mismatch count
//   first_err_*     flag, code and response of the first mismatch
interface decoder_bist_if #(
    parameter int N    = 3,
    parameter int ERRW = 8
);
    localparam int Y = 1 << N;

    logic            start;
    logic [N-1:0]    dec_a;
    logic [Y-1:0]    dec_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_count;
    logic            first_err_valid;
    logic [N-1:0]    first_err_a;
    logic [Y-1:0]    first_err_y;

    modport slave (
        input  start, dec_y,
        output dec_a, busy, done, pass, err_count, first_err_valid, first_err_a, first_err_y
    );

    modport master (
        output start, dec_y,
        input  dec_a, busy, done, pass, err_count, first_err_valid, first_err_a, first_err_y
    );
endinterface

// File: rtl/decoder_bist.sv
// decoder_bist: exhaustive stimulus/response self-test around an N-to-2^N decoder
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      decoder_bist_if.slave: start in, dec_y in, dec_a and all status/result outputs out
module decoder_bist
    import decoder_bist_pkg::*;
#(
    parameter int N      = 3,
    parameter int SETTLE = 1,
    parameter int ERRW   = 8
) (
    input logic           clk,
    input logic           reset_n,
    decoder_bist_if.slave bus
);
    localparam int Y = 1 << N;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    a_q, a_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            fv_q, fv_d;
    logic [N-1:0]    fa_q, fa_d;
    logic [Y-1:0]    fy_q, fy_d;
    logic [Y-1:0]    exp_w;
    logic            start_ok, mism, last;
    logic            busy_w, done_w;

    assign exp_w    = Y'(onehot_of(MAXN'(a_q)));
    assign start_ok = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign mism     = state_q == S_CHECK && bus.dec_y != exp_w;
    assign last     = &a_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = bus.start ? S_SETTLE : state_q;
            S_SETTLE:       state_d = cnt_q == '0 ? S_CHECK : S_SETTLE;
            S_CHECK:        state_d = last ? S_DONE : S_SETTLE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_w = state_q == S_SETTLE || state_q == S_CHECK;
        done_w = state_q == S_DONE;
    end

    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        err_d = err_q;
        fv_d  = fv_q;
        fa_d  = fa_q;
        fy_d  = fy_q;
        if (start_ok) begin
            cnt_d = CNTW'(SETTLE);
            a_d   = '0;
            err_d = '0;
            fv_d  = 1'b0;
            fa_d  = '0;
            fy_d  = '0;
        end
        if (state_q == S_SETTLE && cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (mism) begin
            err_d = &err_q ? err_q : err_q + 1'b1;
            // Only the first mismatch of a run is captured.
            if (!fv_q) begin
                fv_d = 1'b1;
                fa_d = a_q;
                fy_d = bus.dec_y;
            end
        end
        // The last code stays on dec_a through DONE.
        if (state_q == S_CHECK && !last) begin
            a_d   = a_q + 1'b1;
            cnt_d = CNTW'(SETTLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            a_q   <= '0;
            err_q <= '0;
            fv_q  <= 1'b0;
            fa_q  <= '0;
            fy_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            err_q <= err_d;
            fv_q  <= fv_d;
            fa_q  <= fa_d;
            fy_q  <= fy_d;
        end
    end

    assign bus.dec_a           = a_q;
    assign bus.busy            = busy_w;
    assign bus.done            = done_w;
    assign bus.pass            = done_w && err_q == '0;
    assign bus.err_count       = err_q;
    assign bus.first_err_valid = fv_q;
    assign bus.first_err_a     = fa_q;
    assign bus.first_err_y     = fy_q;
endmodule

// File: tb/tb_decoder_bist.sv
// tb_decoder_bist: directed checks of decoder_bist across SETTLE, ERRW and decoder fault models
module tb_decoder_bist;
    import decoder_bist_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;
    int   checks = 0;
    int   failures = 0;

    int lat[4];
    int hold[4][8];
    int lx[4] = '{24, 16, 40, 24};
    int hx[4] = '{3, 2, 5, 3};
    logic [7:0] snap_err;
    logic       snap_fev, snap_busy, snap_done;
    logic [2:0] snap_a;

    always #5 clk = ~clk;

    decoder_bist_if #(.N(3), .ERRW(8)) i0 ();
    decoder_bist_if #(.N(3), .ERRW(8)) i1 ();
    decoder_bist_if #(.N(3), .ERRW(8)) i2 ();
    decoder_bist_if #(.N(3), .ERRW(2)) i3 ();

    decoder_bist #(.N(3), .SETTLE(1), .ERRW(8)) u0 (.clk(clk), .reset_n(reset_n), .bus(i0.slave));
    decoder_bist #(.N(3), .SETTLE(0), .ERRW(8)) u1 (.clk(clk), .reset_n(reset_n), .bus(i1.slave));
    decoder_bist #(.N(3), .SETTLE(3), .ERRW(8)) u2 (.clk(clk), .reset_n(reset_n), .bus(i2.slave));
    decoder_bist #(.N(3), .SETTLE(1), .ERRW(2)) u3 (.clk(clk), .reset_n(reset_n), .bus(i3.slave));

    function automatic logic [7:0] ideal(input logic [2:0] a);
        logic [7:0] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    assign i0.start = start;
    assign i1.start = start;
    assign i2.start = start;
    assign i3.start = start;
    assign i0.dec_y = (mode == 1 && i0.dec_a == 3'd5) ? 8'h00 :
                      (mode == 2 && (i0.dec_a == 3'd2 || i0.dec_a == 3'd6)) ? 8'h44 : ideal(i0.dec_a);
    assign i1.dec_y = ideal(i1.dec_a);
    assign i2.dec_y = ideal(i2.dec_a);
    assign i3.dec_y = 8'hFF;

    logic       bz[4], dn[4];
    logic [2:0] da[4];
    assign bz[0] = i0.busy;  assign dn[0] = i0.done;  assign da[0] = i0.dec_a;
    assign bz[1] = i1.busy;  assign dn[1] = i1.done;  assign da[1] = i1.dec_a;
    assign bz[2] = i2.busy;  assign dn[2] = i2.done;  assign da[2] = i2.dec_a;
    assign bz[3] = i3.busy;  assign dn[3] = i3.done;  assign da[3] = i3.dec_a;

    // Pulses start on all four instances and runs until every one reports done (bounded).
    task automatic run_all(input int extra_start_at);
        bit all_done;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        snap_err = i0.err_count; snap_fev = i0.first_err_valid;
        snap_busy = i0.busy; snap_done = i0.done; snap_a = i0.dec_a;
        for (int k = 0; k < 4; k++) begin
            lat[k] = -1;
            for (int c = 0; c < 8; c++) hold[k][c] = 0;
            if (bz[k]) hold[k][da[k]]++;
        end
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk);
            #1 start = (cyc == extra_start_at);
            all_done = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (bz[k]) hold[k][da[k]]++;
                if (dn[k] && lat[k] < 0) lat[k] = cyc;
                if (lat[k] < 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({i0.busy, i0.done, i0.pass, i0.first_err_valid} !== 4'b0 || i0.dec_a !== 3'd0 || i0.err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold: busy=%b done=%b pass=%b fev=%b a=%0d err=%0d want all 0",
                     i0.busy, i0.done, i0.pass, i0.first_err_valid, i0.dec_a, i0.err_count);
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (u0.state_q !== S_IDLE || i0.busy !== 1'b0 || i0.first_err_a !== 3'd0 || i0.first_err_y !== 8'h00) begin
            failures++;
            $display("FAIL reset_release: state=%0d busy=%b fea=%0d fey=%h want IDLE 0 0 00",
                     u0.state_q, i0.busy, i0.first_err_a, i0.first_err_y);
        end
    endtask

    task automatic test_pass_run;
        mode = 0;
        run_all(-1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lat[k] !== lx[k]) begin
                failures++;
                $display("FAIL latency u%0d: got %0d want %0d", k, lat[k], lx[k]);
            end
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (hold[k][c] !== hx[k]) begin
                    failures++;
                    $display("FAIL hold u%0d code %0d: got %0d want %0d", k, c, hold[k][c], hx[k]);
                end
            end
        end
        checks++;
        if (i0.pass !== 1'b1 || i0.err_count !== 8'd0 || i0.first_err_valid !== 1'b0 || i0.dec_a !== 3'd7) begin
            failures++;
            $display("FAIL good_run: pass=%b err=%0d fev=%b a=%0d want 1 0 0 7",
                     i0.pass, i0.err_count, i0.first_err_valid, i0.dec_a);
        end
        checks++;
        if (i1.pass !== 1'b1 || i2.pass !== 1'b1) begin
            failures++;
            $display("FAIL settle_pass: u1=%b u2=%b want 1 1", i1.pass, i2.pass);
        end
        checks++;
        if (i3.err_count !== 2'd3 || i3.first_err_a !== 3'd0 || i3.first_err_y !== 8'hFF || i3.pass !== 1'b0 || i3.first_err_valid !== 1'b1) begin
            failures++;
            $display("FAIL saturate: err=%0d fea=%0d fey=%h pass=%b fev=%b want 3 0 ff 0 1",
                     i3.err_count, i3.first_err_a, i3.first_err_y, i3.pass, i3.first_err_valid);
        end
    endtask

    task automatic test_fault_zero;
        mode = 1;
        run_all(-1);
        checks++;
        if (i0.err_count !== 8'd1 || i0.first_err_a !== 3'd5 || i0.first_err_y !== 8'h00 || i0.pass !== 1'b0 || i0.first_err_valid !== 1'b1 || i0.done !== 1'b1) begin
            failures++;
            $display("FAIL fault_zero: err=%0d fea=%0d fey=%h pass=%b fev=%b done=%b want 1 5 00 0 1 1",
                     i0.err_count, i0.first_err_a, i0.first_err_y, i0.pass, i0.first_err_valid, i0.done);
        end
    endtask

    task automatic test_restart_from_done;
        mode = 0;
        run_all(-1);
        checks++;
        if (snap_err !== 8'd0 || snap_fev !== 1'b0 || snap_busy !== 1'b1 || snap_done !== 1'b0 || snap_a !== 3'd0) begin
            failures++;
            $display("FAIL restart_clear: err=%0d fev=%b busy=%b done=%b a=%0d want 0 0 1 0 0",
                     snap_err, snap_fev, snap_busy, snap_done, snap_a);
        end
        checks++;
        if (i0.pass !== 1'b1 || lat[0] !== 24) begin
            failures++;
            $display("FAIL restart_run: pass=%b lat=%0d want 1 24", i0.pass, lat[0]);
        end
    endtask

    task automatic test_fault_multi;
        mode = 2;
        run_all(-1);
        checks++;
        if (i0.err_count !== 8'd2 || i0.first_err_a !== 3'd2 || i0.first_err_y !== 8'h44 || i0.pass !== 1'b0) begin
            failures++;
            $display("FAIL fault_multi: err=%0d fea=%0d fey=%h pass=%b want 2 2 44 0",
                     i0.err_count, i0.first_err_a, i0.first_err_y, i0.pass);
        end
    endtask

    task automatic test_start_ignored;
        mode = 0;
        run_all(5);
        checks++;
        if (lat[0] !== 24 || i0.pass !== 1'b1 || hold[0][0] !== 3 || hold[0][1] !== 3 || hold[0][2] !== 3) begin
            failures++;
            $display("FAIL start_busy: lat=%0d pass=%b hold0=%0d hold1=%0d hold2=%0d want 24 1 3 3 3",
                     lat[0], i0.pass, hold[0][0], hold[0][1], hold[0][2]);
        end
    endtask

    task automatic test_midrun_reset;
        mode = 2;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (i0.err_count !== 8'd1 || i0.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre: err=%0d busy=%b want 1 1", i0.err_count, i0.busy);
        end
        @(negedge clk) reset_n = 1'b0;
        #1;
        checks++;
        if ({i0.busy, i0.done, i0.pass, i0.first_err_valid} !== 4'b0 || i0.dec_a !== 3'd0 || i0.err_count !== 8'd0 ||
            i0.first_err_a !== 3'd0 || i0.first_err_y !== 8'h00 || u0.state_q !== S_IDLE) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b done=%b pass=%b fev=%b a=%0d err=%0d fea=%0d fey=%h state=%0d want zeros IDLE",
                     i0.busy, i0.done, i0.pass, i0.first_err_valid, i0.dec_a, i0.err_count,
                     i0.first_err_a, i0.first_err_y, u0.state_q);
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (u0.state_q !== S_IDLE || i0.dec_a !== 3'd0 || i2.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_idle: state=%0d a=%0d u2busy=%b want IDLE 0 0", u0.state_q, i0.dec_a, i2.busy);
        end
    endtask

    initial begin
        test_reset;
        test_pass_run;
        test_fault_zero;
        test_restart_from_done;
        test_fault_multi;
        test_start_ignored;
        test_midrun_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
